// File: rtl/sdram_init_gen.sv
// sdram_init_gen: SDRAM power-up init sequencer (WAIT, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE);
// define SDRAM_INIT_EMRS_EN to add an extended-mode-register load before DONE.
module sdram_init_gen #(
    parameter int               ADDR_W      = 13,
    parameter int               WAIT_CYC    = 20000,
    parameter int               TRP_CYC     = 2,
    parameter int               TRFC_CYC    = 7,
    parameter int               TMRD_CYC    = 3,
    parameter int               AREF_NUM    = 8,
    parameter logic [2:0]       CAS_LAT     = 3'b011,
    parameter logic             BURST_TYPE  = 1'b0,
    parameter logic [2:0]       BURST_LEN   = 3'b111,
    parameter logic             WRITE_BURST = 1'b0,
    parameter logic [ADDR_W-1:0] EMRS_VAL   = '0
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst_n,
    input  logic              i_reinit,
    output logic [3:0]        o_init_cmd,
    output logic [1:0]        o_init_ba,
    output logic [ADDR_W-1:0] o_init_addr,
    output logic              o_init_done,
    output logic              o_init_busy
);
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;
    localparam int TMAX = (TRP_CYC > TRFC_CYC) ? ((TRP_CYC > TMRD_CYC) ? TRP_CYC : TMRD_CYC)
                                               : ((TRFC_CYC > TMRD_CYC) ? TRFC_CYC : TMRD_CYC);
    localparam int TW = $clog2(TMAX + 1);
    localparam int WW = $clog2(WAIT_CYC + 1);
    localparam int RW = $clog2(AREF_NUM + 1);
    localparam logic [ADDR_W-1:0] MODE_VAL =
        {{(ADDR_W-10){1'b0}}, WRITE_BURST, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN};

    typedef enum logic [3:0] {
        S_WAIT, S_PRE, S_TRP, S_AREF, S_TRFC, S_LMR, S_TMRD, S_EMRS, S_TEMRS, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [WW-1:0]     wait_cnt;
    logic [TW-1:0]     tmr;
    logic [RW-1:0]     aref_cnt;
    logic              tmr_run;
    logic [3:0]        cmd_d;
    logic [1:0]        ba_d;
    logic [ADDR_W-1:0] addr_d;

    assign tmr_run = (state == S_TRP) || (state == S_TRFC) || (state == S_TMRD) || (state == S_TEMRS);

    // State register, saturating power-up counter, shared NOP timer and refresh counter
    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
            tmr      <= '0;
            aref_cnt <= '0;
        end else begin
            state    <= state_nxt;
            if (wait_cnt != WW'(WAIT_CYC))
                wait_cnt <= wait_cnt + 1'b1;
            tmr      <= tmr_run ? tmr + 1'b1 : '0;
            aref_cnt <= (state == S_PRE) ? '0 : (state == S_AREF) ? aref_cnt + 1'b1 : aref_cnt;
        end
    end

    // Next-state and command decode for the state just entered
    always_comb begin
        state_nxt = state;
        cmd_d     = CMD_NOP;
        ba_d      = 2'b11;
        addr_d    = '1;
        unique case (state)
            S_WAIT:  state_nxt = (wait_cnt >= WW'(WAIT_CYC - 1)) ? S_PRE : S_WAIT;
            S_PRE: begin
                cmd_d     = CMD_PRE;
                state_nxt = S_TRP;
            end
            S_TRP:   state_nxt = (tmr == TW'(TRP_CYC - 1)) ? S_AREF : S_TRP;
            S_AREF: begin
                cmd_d     = CMD_AREF;
                state_nxt = S_TRFC;
            end
            S_TRFC:  state_nxt = (tmr != TW'(TRFC_CYC - 1)) ? S_TRFC :
                                 (aref_cnt == RW'(AREF_NUM)) ? S_LMR : S_AREF;
            S_LMR: begin
                cmd_d     = CMD_LMR;
                ba_d      = 2'b00;
                addr_d    = MODE_VAL;
                state_nxt = S_TMRD;
            end
`ifdef SDRAM_INIT_EMRS_EN
            S_TMRD:  state_nxt = (tmr == TW'(TMRD_CYC - 1)) ? S_EMRS : S_TMRD;
`else
            S_TMRD:  state_nxt = (tmr == TW'(TMRD_CYC - 1)) ? S_DONE : S_TMRD;
`endif
            S_EMRS: begin
                cmd_d     = CMD_LMR;
                ba_d      = 2'b10;
                addr_d    = EMRS_VAL;
                state_nxt = S_TEMRS;
            end
            S_TEMRS: state_nxt = (tmr == TW'(TMRD_CYC - 1)) ? S_DONE : S_TEMRS;
            S_DONE:  state_nxt = i_reinit ? S_PRE : S_DONE;
            default: state_nxt = S_WAIT;
        endcase
    end

    // Registered outputs, all lagging the state by one cycle
    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            o_init_cmd  <= CMD_NOP;
            o_init_ba   <= 2'b11;
            o_init_addr <= '1;
            o_init_done <= 1'b0;
            o_init_busy <= 1'b0;
        end else begin
            o_init_cmd  <= cmd_d;
            o_init_ba   <= ba_d;
            o_init_addr <= addr_d;
            o_init_done <= (state == S_DONE);
            o_init_busy <= (state != S_DONE) && (state != S_WAIT);
        end
    end
endmodule

// File: tb/tb_sdram_init_gen.sv
// tb_sdram_init_gen: directed cycle-exact check of the init sequence, re-init and async reset.
module tb_sdram_init_gen;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;
    localparam logic [12:0] ONES = 13'h1fff;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n, reinit, reinit2;
    logic [3:0]  cmd1, cmd2;
    logic [1:0]  ba1, ba2;
    logic [12:0] addr1, addr2;
    logic        done1, done2, busy1, busy2;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    sdram_init_gen #(.WAIT_CYC(20), .EMRS_VAL(13'h0020)) dut (
        .i_sysclk(clk), .i_sysrst_n(rst_n), .i_reinit(reinit),
        .o_init_cmd(cmd1), .o_init_ba(ba1), .o_init_addr(addr1),
        .o_init_done(done1), .o_init_busy(busy1)
    );

    sdram_init_gen #(.WAIT_CYC(20), .AREF_NUM(2), .CAS_LAT(3'b010), .BURST_LEN(3'b011),
                     .TRFC_CYC(4), .EMRS_VAL(13'h0020)) dut2 (
        .i_sysclk(clk), .i_sysrst_n(rst2_n), .i_reinit(reinit2),
        .o_init_cmd(cmd2), .o_init_ba(ba2), .o_init_addr(addr2),
        .o_init_done(done2), .o_init_busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cmd,ba,addr,done,busy packed)", tag, obs, exp);
    endtask

    function automatic logic [31:0] obs(input int sel);
        return (sel == 0) ? {11'b0, cmd1, ba1, addr1, done1, busy1}
                          : {11'b0, cmd2, ba2, addr2, done2, busy2};
    endfunction

    task automatic step(input int sel, input logic r, input logic [3:0] c, input logic [1:0] b,
                        input logic [12:0] a, input logic d, input logic y, input string tag);
        if (sel == 0) reinit = r;
        @(posedge clk);
        #1;
        reinit = 1'b0;
        check(tag, obs(sel), {11'b0, c, b, a, d, y});
    endtask

    task automatic wait_phase(input int sel);
        repeat (20) step(sel, 1'b0, NOP, 2'b11, ONES, 1'b0, 1'b0, "wait");
    endtask

    task automatic run_seq(input int sel, input int nref, input int trfc, input logic [12:0] lmr,
                           input int pulse_ref);
        step(sel, 1'b0, PRE, 2'b11, ONES, 1'b0, 1'b1, "pre");
        repeat (2) step(sel, 1'b0, NOP, 2'b11, ONES, 1'b0, 1'b1, "trp");
        for (int i = 1; i <= nref; i++) begin
            step(sel, 1'b0, AREF, 2'b11, ONES, 1'b0, 1'b1, "aref");
            for (int j = 0; j < trfc; j++)
                step(sel, (i == pulse_ref) && (j == 0), NOP, 2'b11, ONES, 1'b0, 1'b1, "trfc");
        end
        step(sel, 1'b0, LMR, 2'b00, lmr, 1'b0, 1'b1, "lmr");
        repeat (3) step(sel, 1'b0, NOP, 2'b11, ONES, 1'b0, 1'b1, "tmrd");
`ifdef SDRAM_INIT_EMRS_EN
        step(sel, 1'b0, LMR, 2'b10, 13'h0020, 1'b0, 1'b1, "emrs");
        repeat (3) step(sel, 1'b0, NOP, 2'b11, ONES, 1'b0, 1'b1, "temrs");
`endif
        step(sel, 1'b0, NOP, 2'b11, ONES, 1'b1, 1'b0, "done");
    endtask

    initial begin
        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        reinit  = 1'b0;
        reinit2 = 1'b0;
        #12;
        check("reset_dut1", obs(0), {11'b0, NOP, 2'b11, ONES, 2'b00});
        check("reset_dut2", obs(1), {11'b0, NOP, 2'b11, ONES, 2'b00});
        @(negedge clk) rst_n = 1'b1;
        wait_phase(0);
        run_seq(0, 8, 7, 13'h0037, 0);
        repeat (3) step(0, 1'b0, NOP, 2'b11, ONES, 1'b1, 1'b0, "done_hold");
        step(0, 1'b1, NOP, 2'b11, ONES, 1'b1, 1'b0, "reinit_edge");
        run_seq(0, 8, 7, 13'h0037, 2);
        step(0, 1'b1, NOP, 2'b11, ONES, 1'b1, 1'b0, "reinit_edge2");
        step(0, 1'b0, PRE, 2'b11, ONES, 1'b0, 1'b1, "pre2");
        repeat (2) step(0, 1'b0, NOP, 2'b11, ONES, 1'b0, 1'b1, "trp2");
        for (int i = 1; i <= 3; i++) begin
            step(0, 1'b0, AREF, 2'b11, ONES, 1'b0, 1'b1, "aref2");
            repeat (7) step(0, 1'b0, NOP, 2'b11, ONES, 1'b0, 1'b1, "trfc2");
        end
        step(0, 1'b0, AREF, 2'b11, ONES, 1'b0, 1'b1, "aref4");
        repeat (2) step(0, 1'b0, NOP, 2'b11, ONES, 1'b0, 1'b1, "trfc4");
        #2 rst_n = 1'b0;
        #1 check("async_rst", obs(0), {11'b0, NOP, 2'b11, ONES, 2'b00});
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_phase(0);
        run_seq(0, 8, 7, 13'h0037, 0);
        @(negedge clk) rst2_n = 1'b1;
        wait_phase(1);
        run_seq(1, 2, 4, 13'h0023, 0);
        step(1, 1'b0, NOP, 2'b11, ONES, 1'b1, 1'b0, "done_hold2");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
